clock_gated_exact_div_16by8: RTL

Iterative restoring divider: the inverse of the 8x8 exact multiplier.
- Takes a 16-bit product-width dividend and a WIDTH-bit divisor.
- Returns a WIDTH-bit quotient and remainder, with overflow and divide-by-zero flags.
- Uses the same clock-gating style as the exact multiplier: all state advances only on enabled cycles.
- Verification uses it to check multiplier results (A*B / B == A), and it serves as a low-power datapath divider.

---
 rtl/div_pkg.sv | 12 +
 rtl/exact_div_step.sv | 21 ++
 rtl/clock_gated_exact_div_16by8.sv | 134 +++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared types and defaults for the clock-gated restoring divider.
package div_pkg;

    localparam int DIV_WIDTH = 8;
    localparam int DIV_CNT_W = $clog2(DIV_WIDTH + 1);

    typedef enum logic {
        IDLE = 1'b0,
        CALC = 1'b1
    } state_t;

endpackage

// File: rtl/exact_div_step.sv
// One restoring-division step: shift in a dividend bit, subtract the divisor if it fits.
module exact_div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH:0]   rem,
    input  logic             din,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   rem_next,
    output logic             q_bit
);

    logic [WIDTH:0] t;

    // rem[WIDTH] would be shifted out of t; if set, the true value already exceeds the divisor.
    assign t        = {rem[WIDTH-1:0], din};
    assign q_bit    = rem[WIDTH] | (t >= {1'b0, divisor});
    assign rem_next = q_bit ? (t - {1'b0, divisor}) : t;

endmodule

// File: rtl/clock_gated_exact_div_16by8.sv
// Iterative 2W-by-W restoring divider; every register advances only on edges with en=1.
module clock_gated_exact_div_16by8
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               start,
    input  logic [2*WIDTH-1:0] Y,
    input  logic [WIDTH-1:0]   B,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   Q,
    output logic [WIDTH-1:0]   R,
    output logic               ovf,
    output logic               dz
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             ovf_q, ovf_d;
    logic             dz_q, dz_d;
    logic             done_q, done_d;

    logic [WIDTH:0]   step_rem;
    logic             step_q;

    exact_div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem_q),
        .din      (sh_q[WIDTH-1]),
        .divisor  (dvs_q),
        .rem_next (step_rem),
        .q_bit    (step_q)
    );

    // Handshake: start is taken on an enabled edge while busy=0; done marks the enabled edge
    // that produced new Q/R/ovf/dz and stays high until the next enabled edge.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        sh_d    = sh_q;
        dvs_d   = dvs_q;
        q_d     = q_q;
        r_d     = r_q;
        ovf_d   = ovf_q;
        dz_d    = dz_q;
        done_d  = done_q;
        case (state_q)
            IDLE: begin
                done_d = 1'b0;
                if (start) begin
                    if (B == '0) begin
                        done_d = 1'b1;
                        dz_d   = 1'b1;
                        ovf_d  = 1'b0;
                        q_d    = '1;
                        r_d    = Y[WIDTH-1:0];
                    end else if (Y[2*WIDTH-1:WIDTH] >= B) begin
                        done_d = 1'b1;
                        dz_d   = 1'b0;
                        ovf_d  = 1'b1;
                        q_d    = '1;
                        r_d    = Y[WIDTH-1:0];
                    end else begin
                        rem_d   = {1'b0, Y[2*WIDTH-1:WIDTH]};
                        sh_d    = Y[WIDTH-1:0];
                        dvs_d   = B;
                        cnt_d   = CW'(WIDTH);
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                done_d = 1'b0;
                rem_d  = step_rem;
                sh_d   = {sh_q[WIDTH-2:0], step_q};
                cnt_d  = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = IDLE;
                    q_d     = {sh_q[WIDTH-2:0], step_q};
                    r_d     = step_rem[WIDTH-1:0];
                    ovf_d   = 1'b0;
                    dz_d    = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            sh_q    <= '0;
            dvs_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            ovf_q   <= 1'b0;
            dz_q    <= 1'b0;
            done_q  <= 1'b0;
        end else if (en) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            sh_q    <= sh_d;
            dvs_q   <= dvs_d;
            q_q     <= q_d;
            r_q     <= r_d;
            ovf_q   <= ovf_d;
            dz_q    <= dz_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q == CALC);
    assign done = done_q;
    assign Q    = q_q;
    assign R    = r_q;
    assign ovf  = ovf_q;
    assign dz   = dz_q;

endmodule
